phase_driver: RTL and testbench
===============================

PHASE_DRIVER -- requirements
Module: phase_driver

Interface
REQ-001 The block SHALL take parameter POS_W, default 16: width of the signed step-position counter.
REQ-002 The block SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port cs, input, 3: current phase state from the step generator (0 = idle, 1..4 = phases, 5..7 illegal).
REQ-005 The block SHALL have port dead_len, input, 4: dead-time length in clk cycles (0..15), sampled when a change is accepted.
REQ-006 The block SHALL have port coil, output, 4: registered one-hot coil drive (bit0 = phase1 .. bit3 = phase4).
REQ-007 The block SHALL have port pos, output, POS_W: registered signed step position.
REQ-008 The block SHALL have port busy, output, 1: high while dead time is in progress.
REQ-009 The block SHALL have port fault, output, 1: sticky error flag.

Function
REQ-010 The block SHALL hold a registered copy cs_q of the last accepted cs; a change is a cycle where cs != cs_q, and is accepted on that rising edge (cs_q <= cs).
REQ-011 The phase pattern map SHALL be: 1->0001, 2->0010, 3->0100, 4->1000; 0 and 5..7 -> 0000.
REQ-012 The FSM SHALL have states IDLE (coil 0000), DEAD (coil 0000, busy 1) and DRIVE (coil = pattern(cs_q)).
REQ-013 On an accepted change to cs=0 the FSM SHALL enter IDLE at that edge from any state, aborting any dead time.
REQ-014 On an accepted change to phase 1..4 with dead_len=0 the FSM SHALL enter DRIVE at that edge, with coil = new pattern after that edge.
REQ-015 On an accepted change to phase 1..4 with dead_len=N>0 the FSM SHALL enter DEAD, hold coil 0000 for exactly N cycles, then enter DRIVE so the new pattern appears after edge k+N (k = accepting edge).
REQ-016 A change accepted during DEAD SHALL restart the dead count with the current dead_len and target the newly accepted phase.
REQ-017 Coil SHALL never show two bits set, nor switch directly between two non-zero patterns when dead_len>0.
REQ-018 For an accepted change between phases p and q (both 1..4): q = p mod 4 + 1 SHALL increment pos; p = q mod 4 + 1 SHALL decrement pos; any other pair SHALL leave pos unchanged and set fault.
REQ-019 Changes from or to 0 SHALL not alter pos.
REQ-020 pos SHALL wrap modulo 2^POS_W (0x7FFF+1 -> 0x8000 for POS_W=16, 0x0000-1 -> 0xFFFF).
REQ-021 An accepted cs of 5..7 SHALL force IDLE, coil 0000, and set fault; pos unchanged.
REQ-022 fault SHALL be sticky and cleared only by reset.
REQ-023 pos update and FSM update for one accepted change SHALL occur on the same edge.

Reset
REQ-024 While reset=0, asynchronously: state IDLE, cs_q=0, dead counter=0, coil=0000, pos=0, busy=0, fault=0.
REQ-025 After reset release, the first edge with cs!=0 SHALL be treated as an accepted change from 0.
REQ-026 Reset asserted during DEAD or DRIVE SHALL take effect immediately, without waiting for a clock edge.

Verification
REQ-027 dead_len=0, cs 0->1->2->3->4->1 one per 4 cycles -> coil 0001,0010,0100,1000,0001 one edge after each change; pos ends +4; busy never 1.
REQ-028 dead_len=3, cs 1->2 at edge k -> coil 0000 and busy=1 after edges k..k+2; coil 0010, busy=0 after edge k+3; pos +1.
REQ-029 dead_len=3, cs 1->4 then 4->3 two cycles later -> dead count restarts, coil 0100 three edges after second change; pos -2.
REQ-030 cs 1->3 -> fault=1, pos unchanged, coil 0100 after dead time; cs=6 -> coil 0000, IDLE; fault stays 1 until reset.
REQ-031 pos preset by 32767 forward steps, one more forward step -> pos=0x8000; reverse step from reset -> pos=0xFFFF.
REQ-032 reset pulled low mid-DEAD between edges -> coil, pos, busy, fault all 0 immediately; after release cs=2 -> DEAD/DRIVE without pos change.

Source files
------------

// File: rtl/phase_driver.sv
// phase_driver
// Turns the phase number from the step generator into a one-hot coil drive,
// inserting a programmable dead time (all coils off) between patterns, and
// keeps a signed step position plus a sticky fault flag.
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-low
//   cs        in   3  phase state: 0 idle, 1..4 phases, 5..7 illegal
//   dead_len  in   4  dead-time length in clk cycles, sampled on a change
//   coil      out  4  registered one-hot coil drive (bit0 = phase1)
//   pos       out  POS_W registered signed step position (wraps)
//   busy      out  1  high while dead time is running
//   fault     out  1  sticky: illegal cs or non-adjacent phase jump
//
// state    | meaning
// ST_IDLE  | coils off, waiting for a phase
// ST_DEAD  | coils off, counting dead time before the new pattern
// ST_DRIVE | coil = pattern of the last accepted phase
module phase_driver #(
   parameter int POS_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       cs,
   input  logic [3:0]       dead_len,
   output logic [3:0]       coil,
   output logic [POS_W-1:0] pos,
   output logic             busy,
   output logic             fault
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DEAD  = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_cs_q;
   logic [3:0]       r_dead_cnt;
   logic [3:0]       w_dead_cnt_nxt;
   logic [3:0]       r_coil;
   logic [3:0]       w_coil_nxt;
   logic [POS_W-1:0] r_pos;
   logic [POS_W-1:0] w_pos_nxt;
   logic             r_fault;
   logic             w_fault_nxt;

   logic w_change;
   logic w_new_phase;
   logic w_old_phase;
   logic w_fwd;
   logic w_rev;
   logic w_illegal;

   function automatic logic [3:0] pattern(input logic [2:0] p);
      case (p)
         3'd1:    pattern = 4'b0001;
         3'd2:    pattern = 4'b0010;
         3'd3:    pattern = 4'b0100;
         3'd4:    pattern = 4'b1000;
         default: pattern = 4'b0000;
      endcase
   endfunction

   function automatic logic [2:0] next_phase(input logic [2:0] p);
      next_phase = (p == 3'd4) ? 3'd1 : p + 3'd1;
   endfunction

   assign w_change    = (cs != r_cs_q);
   assign w_new_phase = (cs >= 3'd1) && (cs <= 3'd4);
   assign w_old_phase = (r_cs_q >= 3'd1) && (r_cs_q <= 3'd4);
   assign w_fwd       = (cs == next_phase(r_cs_q));
   assign w_rev       = (r_cs_q == next_phase(cs));
   assign w_illegal   = (cs > 3'd4);

   always_comb begin
      w_state_nxt    = r_state;
      w_dead_cnt_nxt = r_dead_cnt;
      w_pos_nxt      = r_pos;
      w_fault_nxt    = r_fault;

      if (w_change) begin
         if (w_new_phase && w_old_phase) begin
            if (w_fwd)
               w_pos_nxt = r_pos + POS_W'(1);
            else if (w_rev)
               w_pos_nxt = r_pos - POS_W'(1);
            else
               w_fault_nxt = 1'b1;
         end

         if (w_illegal) begin
            w_state_nxt    = ST_IDLE;
            w_dead_cnt_nxt = 4'd0;
            w_fault_nxt    = 1'b1;
         end else if (cs == 3'd0) begin
            w_state_nxt    = ST_IDLE;
            w_dead_cnt_nxt = 4'd0;
         end else if (dead_len == 4'd0) begin
            w_state_nxt    = ST_DRIVE;
            w_dead_cnt_nxt = 4'd0;
         end else begin
            // Counter holds remaining cycles after this edge, so a length of
            // N yields exactly N samples with coils off.
            w_state_nxt    = ST_DEAD;
            w_dead_cnt_nxt = dead_len - 4'd1;
         end
      end else begin
         case (r_state)
            ST_DEAD: begin
               if (r_dead_cnt == 4'd0)
                  w_state_nxt = ST_DRIVE;
               else
                  w_dead_cnt_nxt = r_dead_cnt - 4'd1;
            end
            default: ;
         endcase
      end

      // cs_q takes cs every edge, so the pattern after the edge is pattern(cs).
      w_coil_nxt = (w_state_nxt == ST_DRIVE) ? pattern(cs) : 4'b0000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cs_q     <= 3'd0;
         r_dead_cnt <= 4'd0;
         r_coil     <= 4'b0000;
         r_pos      <= '0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cs_q     <= cs;
         r_dead_cnt <= w_dead_cnt_nxt;
         r_coil     <= w_coil_nxt;
         r_pos      <= w_pos_nxt;
         r_fault    <= w_fault_nxt;
      end
   end

   assign coil  = r_coil;
   assign pos   = r_pos;
   assign busy  = (r_state == ST_DEAD);
   assign fault = r_fault;

endmodule

// File: tb/tb_phase_driver.sv
// Testbench for phase_driver: directed phase sequences, expected outputs
// queued per clock by the stimulus and compared by an independent monitor.
module tb_phase_driver;

   logic        clk;
   logic        reset;
   logic [2:0]  cs;
   logic [3:0]  dead_len;
   logic [3:0]  coil;
   logic [15:0] pos;
   logic        busy;
   logic        fault;

   typedef struct packed {
      logic [3:0]  coil;
      logic        busy;
      logic [15:0] pos;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   mon_idx = 0;

   phase_driver #(.POS_W(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .cs       (cs),
      .dead_len (dead_len),
      .coil     (coil),
      .pos      (pos),
      .busy     (busy),
      .fault    (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input int idx,
                               input int unsigned act, input int unsigned exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s @%0d: got 0x%0h expected 0x%0h", name, idx, act, exp_v);
      end
   endfunction

   function automatic logic [3:0] pat(input int c);
      pat = 4'b0001 << (c - 1);
   endfunction

   // Monitor: outputs are registered, so every sample after an edge is a
   // presented response; pop one expectation per sample.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("coil",  mon_idx, coil,  mon_e.coil);
            chk("busy",  mon_idx, busy,  mon_e.busy);
            chk("pos",   mon_idx, pos,   mon_e.pos);
            chk("fault", mon_idx, fault, mon_e.fault);
            mon_idx++;
         end
      end
   end

   task automatic cyc(input logic [2:0] c, input logic [3:0] d,
                      input logic [3:0] ec, input logic eb,
                      input logic [15:0] ep, input logic ef);
      exp_t e;
      cs       = c;
      dead_len = d;
      @(posedge clk);
      e.coil  = ec;
      e.busy  = eb;
      e.pos   = ep;
      e.fault = ef;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic hold4(input logic [2:0] c, input logic [3:0] ec, input logic [15:0] ep);
      for (int i = 0; i < 4; i++) cyc(c, 4'd0, ec, 1'b0, ep, 1'b0);
   endtask

   // Asserts reset between edges and checks outputs clear without a clock.
   task automatic do_reset(input int tag);
      @(negedge clk);
      #1;
      reset    = 1'b0;
      cs       = 3'd0;
      dead_len = 4'd0;
      #1;
      chk("rst_coil",  tag, coil,  0);
      chk("rst_busy",  tag, busy,  0);
      chk("rst_pos",   tag, pos,   0);
      chk("rst_fault", tag, fault, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset    = 1'b0;
      cs       = 3'd0;
      dead_len = 4'd0;
      #12;
      chk("init_coil",  0, coil,  0);
      chk("init_busy",  0, busy,  0);
      chk("init_pos",   0, pos,   0);
      chk("init_fault", 0, fault, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Zero dead time, forward sequence 0->1->2->3->4->1
      cyc(3'd0, 4'd0, 4'b0000, 1'b0, 16'd0, 1'b0);
      hold4(3'd1, 4'b0001, 16'd0);
      hold4(3'd2, 4'b0010, 16'd1);
      hold4(3'd3, 4'b0100, 16'd2);
      hold4(3'd4, 4'b1000, 16'd3);
      hold4(3'd1, 4'b0001, 16'd4);

      // Dead time 3, 1->2
      for (int i = 0; i < 3; i++) cyc(3'd2, 4'd3, 4'b0000, 1'b1, 16'd5, 1'b0);
      cyc(3'd2, 4'd3, 4'b0010, 1'b0, 16'd5, 1'b0);

      // Back to 1, then 1->4 and 4->3 inside the dead window
      for (int i = 0; i < 3; i++) cyc(3'd1, 4'd3, 4'b0000, 1'b1, 16'd4, 1'b0);
      cyc(3'd1, 4'd3, 4'b0001, 1'b0, 16'd4, 1'b0);
      for (int i = 0; i < 2; i++) cyc(3'd4, 4'd3, 4'b0000, 1'b1, 16'd3, 1'b0);
      for (int i = 0; i < 3; i++) cyc(3'd3, 4'd3, 4'b0000, 1'b1, 16'd2, 1'b0);
      cyc(3'd3, 4'd3, 4'b0100, 1'b0, 16'd2, 1'b0);

      // Walk back to 1, then non-adjacent 1->3 and illegal cs=6
      cyc(3'd2, 4'd0, 4'b0010, 1'b0, 16'd1, 1'b0);
      cyc(3'd1, 4'd0, 4'b0001, 1'b0, 16'd0, 1'b0);
      for (int i = 0; i < 2; i++) cyc(3'd3, 4'd2, 4'b0000, 1'b1, 16'd0, 1'b1);
      cyc(3'd3, 4'd2, 4'b0100, 1'b0, 16'd0, 1'b1);
      cyc(3'd6, 4'd2, 4'b0000, 1'b0, 16'd0, 1'b1);
      cyc(3'd6, 4'd2, 4'b0000, 1'b0, 16'd0, 1'b1);
      cyc(3'd0, 4'd0, 4'b0000, 1'b0, 16'd0, 1'b1);
      cyc(3'd2, 4'd0, 4'b0010, 1'b0, 16'd0, 1'b1);

      // Fault cleared only by reset; then 32768 forward steps to 0x8000
      do_reset(1);
      cyc(3'd1, 4'd0, 4'b0001, 1'b0, 16'd0, 1'b0);
      for (int i = 1; i <= 32768; i++) begin
         cyc(3'((i % 4) + 1), 4'd0, pat((i % 4) + 1), 1'b0, 16'(i), 1'b0);
      end

      // Reverse step from reset wraps to 0xFFFF, forward wraps back to 0
      do_reset(2);
      cyc(3'd1, 4'd0, 4'b0001, 1'b0, 16'h0000, 1'b0);
      cyc(3'd4, 4'd0, 4'b1000, 1'b0, 16'hFFFF, 1'b0);
      cyc(3'd1, 4'd0, 4'b0001, 1'b0, 16'h0000, 1'b0);

      // Reset asserted mid-dead-time
      do_reset(3);
      cyc(3'd1, 4'd3, 4'b0000, 1'b1, 16'd0, 1'b0);
      cyc(3'd2, 4'd3, 4'b0000, 1'b1, 16'd1, 1'b0);
      cyc(3'd2, 4'd3, 4'b0000, 1'b1, 16'd1, 1'b0);
      do_reset(4);
      for (int i = 0; i < 3; i++) cyc(3'd2, 4'd3, 4'b0000, 1'b1, 16'd0, 1'b0);
      cyc(3'd2, 4'd3, 4'b0010, 1'b0, 16'd0, 1'b0);
      cyc(3'd2, 4'd3, 4'b0010, 1'b0, 16'd0, 1'b0);

      @(negedge clk);
      #1;
      chk("queue_drained", 0, exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
